// File: rtl/canny_window_gen.sv
// canny_window_gen: raster pixel stream to 3x3 neighbourhood windows for the Sobel stage
// Ports: clk; reset (async, active-low); pix_in/pix_valid/frame_start raster stream in;
//        im11..im33 window rows r-2..r, left->right, im33 newest; start strobe with
//        cen_x/cen_y window centre; frame_done pulse after last pixel; busy while ACTIVE.
module canny_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          frame_start,
    output logic [DW-1:0] im11,
    output logic [DW-1:0] im12,
    output logic [DW-1:0] im13,
    output logic [DW-1:0] im21,
    output logic [DW-1:0] im22,
    output logic [DW-1:0] im23,
    output logic [DW-1:0] im31,
    output logic [DW-1:0] im32,
    output logic [DW-1:0] im33,
    output logic          start,
    output logic [15:0]   cen_x,
    output logic [15:0]   cen_y,
    output logic          frame_done,
    output logic          busy
);
    localparam int AW = IMG_W > 1 ? $clog2(IMG_W) : 1;
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;
    logic [15:0] col, row, c, r;
    logic acc, last_col, last_row;
    logic [AW-1:0] addr;
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb0_q, lb1_q;
    // A frame_start pixel is always (0,0), even when it aborts a frame in progress.
    always_comb begin
        acc = pix_valid && (frame_start || state == ACTIVE);
        c = frame_start ? 16'd0 : col;
        r = frame_start ? 16'd0 : row;
        last_col = c == 16'(IMG_W - 1);
        last_row = r == 16'(IMG_H - 1);
        addr = AW'(c);
        lb0_q = lb0[addr];
        lb1_q = lb1[addr];
    end
    // Read-before-write: the old line-1 value moves down into line 0 at the same column.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[addr] <= pix_in;
            lb0[addr] <= lb1_q;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            col <= '0;
            row <= '0;
            {im11, im12, im13, im21, im22, im23, im31, im32, im33} <= '0;
            start <= 1'b0;
            frame_done <= 1'b0;
            cen_x <= '0;
            cen_y <= '0;
        end else begin
            start <= acc && r >= 16'd2 && c >= 16'd2;
            frame_done <= acc && last_col && last_row;
            if (acc) begin
                {im11, im12, im13} <= {im12, im13, lb0_q};
                {im21, im22, im23} <= {im22, im23, lb1_q};
                {im31, im32, im33} <= {im32, im33, pix_in};
                col <= last_col ? 16'd0 : c + 16'd1;
                row <= !last_col ? r : last_row ? 16'd0 : r + 16'd1;
                state <= last_col && last_row ? IDLE : ACTIVE;
                if (r >= 16'd2 && c >= 16'd2) begin
                    cen_x <= c - 16'd1;
                    cen_y <= r - 16'd1;
                end
            end
        end
    end
    assign busy = state == ACTIVE;
endmodule

// File: tb/tb_canny_window_gen.sv
// tb_canny_window_gen: directed checks of canny_window_gen in 4x4 and 5x3 configurations
module tb_canny_window_gen;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [DW-1:0] pix = '0;
    logic valid = 1'b0;
    logic fs = 1'b0;
    logic [DW-1:0] a11, a12, a13, a21, a22, a23, a31, a32, a33;
    logic [DW-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
    logic a_start, a_done, a_busy, b_start, b_done, b_busy;
    logic [15:0] a_cx, a_cy, b_cx, b_cy;
    int n_vec = 0;
    int n_err = 0;
    int a_fd = 0;
    logic v_edge = 1'b0;
    logic [DW*9-1:0] q_w[$];
    int q_cx[$], q_cy[$], qb_cx[$], qb_cy[$];

    always #5 clk = ~clk;

    canny_window_gen #(.IMG_W(4), .IMG_H(4), .DW(DW)) u_a (
        .clk(clk), .reset(reset), .pix_in(pix), .pix_valid(valid), .frame_start(fs),
        .im11(a11), .im12(a12), .im13(a13), .im21(a21), .im22(a22), .im23(a23),
        .im31(a31), .im32(a32), .im33(a33), .start(a_start), .cen_x(a_cx), .cen_y(a_cy),
        .frame_done(a_done), .busy(a_busy));

    canny_window_gen #(.IMG_W(5), .IMG_H(3), .DW(DW)) u_b (
        .clk(clk), .reset(reset), .pix_in(pix), .pix_valid(valid), .frame_start(fs),
        .im11(b11), .im12(b12), .im13(b13), .im21(b21), .im22(b22), .im23(b23),
        .im31(b31), .im32(b32), .im33(b33), .start(b_start), .cen_x(b_cx), .cen_y(b_cy),
        .frame_done(b_done), .busy(b_busy));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) v_edge <= valid;

    always @(negedge clk) begin
        if (a_start) begin
            q_w.push_back({a11, a12, a13, a21, a22, a23, a31, a32, a33});
            q_cx.push_back(int'(a_cx));
            q_cy.push_back(int'(a_cy));
            chk("start_after_valid", 32'(v_edge), 1);
        end
        if (b_start) begin
            qb_cx.push_back(int'(b_cx));
            qb_cy.push_back(int'(b_cy));
        end
        if (a_done) begin
            a_fd++;
            chk("busy_with_done", 32'(a_busy), 0);
        end
    end

    task automatic send(input bit v, input bit f, input int p);
        valid = v;
        fs = f;
        pix = DW'(p);
        @(posedge clk);
        #1;
        valid = 1'b0;
        fs = 1'b0;
    endtask

    task automatic frame(input int w, input int h, input int base, input bit stall);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                if (stall) begin
                    int n = $urandom_range(0, 2);
                    for (int k = 0; k < n; k++) send(0, 0, 999);
                end
                send(1, r == 0 && c == 0, base + 10 * r + c);
            end
    endtask

    task automatic clear();
        q_w.delete();
        q_cx.delete();
        q_cy.delete();
        qb_cx.delete();
        qb_cy.delete();
        a_fd = 0;
    endtask

    // Pops n windows of a 4x4 frame in raster order of centres (1,1),(2,1),(1,2),(2,2).
    task automatic check_windows(input int base, input int n);
        chk("window_count", 32'(q_w.size() >= n), 1);
        for (int k = 0; k < n && q_w.size() > 0; k++) begin
            logic [DW*9-1:0] w = q_w.pop_front();
            int cx = 1 + k % 2;
            int cy = 1 + k / 2;
            chk("cen_x", 32'(q_cx.pop_front()), 32'(cx));
            chk("cen_y", 32'(q_cy.pop_front()), 32'(cy));
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    chk("im", 32'(w[DW*(8 - 3*i - j) +: DW]), 32'(base + 10 * (cy - 1 + i) + (cx - 1 + j)));
        end
    endtask

    initial begin
        #2;
        chk("rst_start", 32'(a_start), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_im", 32'(|{a11, a12, a13, a21, a22, a23, a31, a32, a33}), 0);
        chk("rst_cen", 32'({a_cx, a_cy}), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        send(0, 0, 0);

        // basic 4x4 frame, first window literal
        clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                send(1, r == 0 && c == 0, 10 * r + c);
                if (r == 0 && c == 0) chk("busy_on", 32'(a_busy), 1);
            end
        chk("done_pulse", 32'(a_done), 1);
        chk("busy_off", 32'(a_busy), 0);
        send(0, 0, 0);
        chk("done_one_cycle", 32'(a_done), 0);
        chk("win_total", 32'(q_w.size()), 4);
        if (q_w.size() > 0) chk("first_window", 32'(q_w[0] == {16'd0, 16'd1, 16'd2, 16'd10, 16'd11, 16'd12, 16'd20, 16'd21, 16'd22}), 1);
        check_windows(0, 4);
        chk("fd_count", 32'(a_fd), 1);

        // stalls
        clear();
        frame(4, 4, 0, 1);
        repeat (3) send(0, 0, 0);
        chk("stall_total", 32'(q_w.size()), 4);
        check_windows(0, 4);

        // 5x3 line-wrap suppression
        reset = 1'b0;
        #1;
        reset = 1'b1;
        clear();
        frame(5, 3, 0, 0);
        repeat (2) send(0, 0, 0);
        chk("wrap_count", 32'(qb_cx.size()), 3);
        for (int k = 0; k < 3 && qb_cx.size() > 0; k++) begin
            chk("wrap_cx", 32'(qb_cx.pop_front()), 32'(k + 1));
            chk("wrap_cy", 32'(qb_cy.pop_front()), 1);
        end

        // idle pixels ignored, then abort at (2,2) and restart
        reset = 1'b0;
        #1;
        reset = 1'b1;
        clear();
        for (int k = 0; k < 12; k++) send(1, 0, 500 + k);
        chk("idle_busy", 32'(a_busy), 0);
        chk("idle_nowin", 32'(q_w.size()), 0);
        for (int k = 0; k < 10; k++) send(1, k == 0, 200 + 10 * (k / 4) + k % 4);
        chk("abort_nowin", 32'(q_w.size()), 0);
        frame(4, 4, 100, 0);
        send(0, 0, 0);
        chk("restart_total", 32'(q_w.size()), 4);
        check_windows(100, 4);
        chk("abort_fd", 32'(a_fd), 1);

        // async reset mid-frame
        clear();
        for (int k = 0; k < 11; k++) send(1, k == 0, 300 + 10 * (k / 4) + k % 4);
        chk("pre_reset_start", 32'(a_start), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_start", 32'(a_start), 0);
        chk("ar_busy", 32'(a_busy), 0);
        chk("ar_im", 32'(|{a11, a12, a13, a21, a22, a23, a31, a32, a33}), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear();
        frame(4, 4, 50, 0);
        send(0, 0, 0);
        chk("ar_total", 32'(q_w.size()), 4);
        check_windows(50, 4);

        // back-to-back frames
        clear();
        frame(4, 4, 0, 0);
        frame(4, 4, 100, 0);
        repeat (2) send(0, 0, 0);
        chk("b2b_total", 32'(q_w.size()), 8);
        check_windows(0, 4);
        check_windows(100, 4);
        chk("b2b_fd", 32'(a_fd), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
